alu_mul_seq: RTL and testbench

- Iterative 32x32 -> 64-bit unsigned multiply sequencer (UMULL-style) that drives the shared 32-bit ALU.
- Runs shift-add: one ALU add per cycle, with the ALU carry flag feeding the high word.
- Sits beside the ALU in the multi-cycle execute stage. The execute controller grants it the ALU and consumes the result over a valid/ready handshake.

---
 rtl/alu_mul_seq.sv | 135 +++++++++++++
 tb/tb_alu_mul_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative 32x32->64 unsigned multiply (shift-add) on the shared ALU.
// Ports: clk, reset (async high), start_valid/start_ready + op_a/op_b in;
//   alu_busy/alu_srca/alu_srcb/alu_ctrl out, alu_result/alu_flags in;
//   res_valid/res_ready + res_lo/res_hi/res_n/res_z out.
// Optional: `define MUL_EARLY_EXIT_EN to finish once remaining multiplier bits are zero.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             alu_busy,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             res_n,
  output logic             res_z
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             cy;
  logic             busy;
  logic             done;

  // Only the carry flag participates in the product.
  logic unused_flags;
  assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  assign cy = alu_flags[1];

`ifdef MUL_EARLY_EXIT_EN
  // Low (WIDTH-k) bits of M are the multiplier bits still to process.
  logic [WIDTH-1:0] rest_mask;
  logic             rest_zero;
  logic [CNT_W:0]   shamt;

  assign rest_mask = {WIDTH{1'b1}} >> k_q;
  assign rest_zero = (m_q & rest_mask) == '0;
  assign shamt     = (CNT_W+1)'(WIDTH) - {1'b0, k_q};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      h_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      h_q     <= h_d;
      m_q     <= m_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    h_d     = h_q;
    m_d     = m_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          m_d     = op_b;
          h_d     = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MUL_EARLY_EXIT_EN
        if (rest_zero) begin
          // Skipped iterations would only shift zeros in.
          {h_d, m_d} = {h_q, m_q} >> shamt;
          state_d    = DONE;
        end else
`endif
        begin
          if (m_q[0])
            {h_d, m_d} = {cy, alu_result, m_q[WIDTH-1:1]};
          else
            {h_d, m_d} = {1'b0, h_q, m_q[WIDTH-1:1]};
          k_d = k_q + 1'b1;
          if (k_q == CNT_W'(WIDTH-1))
            state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  assign start_ready = (state_q == IDLE);
  assign alu_busy    = busy;
  assign alu_ctrl    = 2'b00;
  assign alu_srca    = busy ? h_q : '0;
  assign alu_srcb    = busy ? a_q : '0;

  assign res_valid = done;
  assign res_lo    = done ? m_q : '0;
  assign res_hi    = done ? h_q : '0;
  assign res_n     = done & h_q[WIDTH-1];
  assign res_z     = done & (h_q == '0) & (m_q == '0);

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed scoreboard bench for alu_mul_seq.
// Driver pushes expected products; a negedge monitor pops and compares.
module tb_alu_mul_seq;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        alu_busy;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [1:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        res_n;
  logic        res_z;

  logic [32:0] alu_sum;

  alu_mul_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_busy   (alu_busy),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .res_n      (res_n),
    .res_z      (res_z)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add with {N,Z,C,V} flags.
  assign alu_sum    = {1'b0, alu_srca} + {1'b0, alu_srcb};
  assign alu_result = alu_sum[31:0];
  assign alu_flags  = {alu_sum[31], (alu_sum[31:0] == 32'd0),
                       alu_sum[32], 1'b0};

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   seen     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int lat(input int ee_lat);
    return EE ? ee_lat : 33;
  endfunction

  // Monitor: compares whenever the DUT presents a product.
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(res_valid), 64'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 64'(cyc - q[0].t), 64'(q[0].lat));
        end
        chk("res_lo", 64'(res_lo), 64'(q[0].lo));
        chk("res_hi", 64'(res_hi), 64'(q[0].hi));
        if (res_ready) begin
          chk("res_n", 64'(res_n), 64'(q[0].hi[31]));
          chk("res_z", 64'(res_z),
              64'((q[0].hi == 32'd0) && (q[0].lo == 32'd0)));
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input int l);
    int n = 0;
    while (!start_ready && n < 200) begin
      step();
      n++;
    end
    chk("start_ready_wait", 64'(start_ready), 64'd1);
    op_a        = a;
    op_b        = b;
    start_valid = 1'b1;
    q.push_back(exp_t'{lo, hi, l, cyc});
    step();
    start_valid = 1'b0;
    op_a        = ~a;
    op_b        = ~b;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int rd;
    reset       = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    op_a        = '0;
    op_b        = '0;
    step();
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_busy", 64'(alu_busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_outs", {res_hi, res_lo}, 64'd0);
    chk("rst_src", {alu_srca, alu_srcb}, 64'd0);
    chk("rst_flags", 64'({res_n, res_z, alu_ctrl}), 64'd0);
    step();
    reset = 1'b0;
    step();

    issue(32'd3, 32'd5, 32'h0000000F, 32'd0, lat(5));
    chk("run_busy", 64'(alu_busy), 64'd1);
    chk("run_ctrl", 64'(alu_ctrl), 64'd0);
    chk("run_srcb", 64'(alu_srcb), 64'd3);
    drain();

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 33);
    drain();
    issue(32'h12345678, 32'd0, 32'd0, 32'd0, lat(2));
    drain();
    issue(32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 33);
    drain();
    issue(32'h00010000, 32'h00010000, 32'd0, 32'd1, lat(19));
    drain();
    issue(32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 32'd0, lat(18));
    drain();

    // Back-pressure: hold result for 10 cycles, ignore new requests.
    res_ready = 1'b0;
    issue(32'h80000000, 32'd2, 32'd0, 32'd1, lat(4));
    n = 0;
    while (!res_valid && n < 200) begin
      step();
      n++;
    end
    chk("hold_valid_seen", 64'(res_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'b1;
      op_a        = 32'd5;
      op_b        = 32'd5;
      @(negedge clk);
      chk("hold_start_ready", 64'(start_ready), 64'd0);
      chk("hold_valid", 64'(res_valid), 64'd1);
      step();
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    step();
    chk("hold_idle_ready", 64'(start_ready), 64'd1);
    chk("hold_idle_valid", 64'(res_valid), 64'd0);
    chk("hold_queue", 64'(q.size()), 64'd0);

    // Reset in the middle of a multiply.
    rd = EE ? 3 : 12;
    issue(32'd7, 32'd9, 32'd63, 32'd0, lat(6));
    repeat (rd - 1) step();
    chk("pre_rst_busy", 64'(alu_busy), 64'd1);
    chk("pre_rst_srcb", 64'(alu_srcb), 64'd7);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(alu_busy), 64'd0);
    chk("mid_rst_ready", 64'(start_ready), 64'd1);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_outs", {res_hi, res_lo}, 64'd0);
    chk("mid_rst_src", {alu_srca, alu_srcb}, 64'd0);
    chk("mid_rst_nz", 64'({res_n, res_z}), 64'd0);
    q.delete();
    seen = 1'b0;
    step();
    reset = 1'b0;
    step();
    issue(32'd7, 32'd9, 32'd63, 32'd0, lat(6));
    drain();

    issue(32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 32'd0, lat(3));
    drain();

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
